usr_access_capture: RTL and testbench
=====================================

# usr_access_capture

Parametrised, double-buffered capture of multi-word user-access configuration data. Accepts a DINVALID-qualified word stream from the configuration interface (already in the CLK domain), assembles NUM_WORDS-word frames, and atomically swaps each complete frame into a read bank. On request, it drains the read bank over a valid/ready stream. It also flags content changes, malformed frames and overruns, so system logic can track bitstream and user-register identity across reconfiguration.

## Interface
- DATA_WIDTH, 32, width of each captured word (≥1)
- NUM_WORDS, 4, words per frame (≥2); index width IW = clog2(NUM_WORDS)
- CNT_WIDTH, 16, width of FRAME_CNT
- Clock and reset: one clock; reset is asynchronous and active-high.
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  asynchronous active-high reset
- DIN  in  DATA_WIDTH  incoming configuration word
- DINVALID  in  1  DIN valid this cycle
- START  in  1  single-cycle request to drain the read bank
- M_DATA  out  DATA_WIDTH  drained word
- M_VALID  out  1  M_DATA valid
- M_READY  in  1  downstream accepts the word
- M_LAST  out  1  marks word NUM_WORDS-1 of a drain
- SNAP_VALID  out  1  read bank holds at least one complete frame
- CHANGED  out  1  one-cycle pulse; new read bank differs from the previous one, or is the first frame
- FRAME_ERR  out  1  one-cycle pulse; frame aborted by a gap
- OVERRUN  out  1  one-cycle pulse; pending frame overwritten before it was swapped in
- FRAME_CNT  out  CNT_WIDTH  count of completed frames, wraps

## Operation
- Storage: two banks of NUM_WORDS×DATA_WIDTH. The fill bank is written from DIN; the read bank feeds M_DATA. A bank-select bit swaps their roles.
- Fill pointer wr_idx (IW bits):
  - Each DINVALID cycle writes DIN to fill[wr_idx] and increments wr_idx.
  - On the NUM_WORDS-th word, wr_idx returns to 0 and the frame completes.
- Gap rule: DINVALID low while 0 < wr_idx < NUM_WORDS → FRAME_ERR pulse and wr_idx := 0. The partial frame is discarded and the read bank is untouched.
- Change detect:
  - diff flag clears at word 0 of each frame.
  - diff flag ORs in (DIN != rd[wr_idx]) for each word written.
  - diff is forced to 1 while SNAP_VALID = 0.
- Frame completion:
  - Not draining: swap on the completion edge. SNAP_VALID := 1, CHANGED := diff, FRAME_CNT += 1.
  - Draining: the swap is held pending and FRAME_CNT increments immediately. The swap executes on the edge of the final handshake (M_LAST & M_READY), and CHANGED pulses there.
  - Pending already set when another frame completes: OVERRUN pulse, the newer frame wins, and diff is recomputed against the current read bank.
- The fill bank must not be written while a pending swap holds it. A new frame started while pending writes the alternate bank if free. Otherwise the fill bank is overwritten, covered by the OVERRUN rule.
- Drain FSM states: IDLE and DRAIN.
  - IDLE → DRAIN on START & SNAP_VALID; rd_idx := 0.
  - START is ignored in DRAIN or while SNAP_VALID = 0.
  - In DRAIN: M_VALID = 1, M_DATA = rd[rd_idx], M_LAST = (rd_idx == NUM_WORDS-1).
  - A handshake increments rd_idx. A handshake with M_LAST → IDLE.
  - M_DATA and M_LAST stay stable while M_VALID & !M_READY.
- Simultaneous events:
  - DINVALID and a drain run concurrently.
  - Frame completion on the same edge as the final handshake: swap immediately, no OVERRUN.

## Timing
- Reset values: M_VALID, M_LAST, SNAP_VALID, CHANGED, FRAME_ERR and OVERRUN are 0; FRAME_CNT is 0; M_DATA is 0; FSM is IDLE; wr_idx, rd_idx, pending and bank-select are 0.
- Reset mid-operation: all outputs drop asynchronously. The frame in progress and the stored banks are discarded (SNAP_VALID = 0).
- Frame with words on cycles 0..N-1: SNAP_VALID, CHANGED and FRAME_CNT update after the edge ending cycle N-1, and are visible in cycle N.
- START sampled in cycle t → M_VALID = 1 in cycle t+1.
- Drain throughput: one word per cycle with M_READY held high; a full drain takes NUM_WORDS cycles.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- Reset, then DIN = 0x11,0x22,0x33,0x44 on 4 consecutive DINVALID cycles → SNAP_VALID = 1, CHANGED pulse, FRAME_CNT = 1. START → M_DATA 0x11..0x44 on 4 cycles, M_LAST on 0x44.
- Repeat the identical frame → FRAME_CNT = 2, no CHANGED. Then send a frame with word 2 = 0x99 → CHANGED pulse, and the drain returns 0x11,0x22,0x99,0x44.
- Send 2 words, drop DINVALID for 1 cycle → FRAME_ERR pulse. Then a full frame 0xA0..0xA3 → the read bank holds exactly 0xA0..0xA3.
- START with M_READY low for 5 cycles, while a new frame completes mid-drain → M_DATA is held, the drain returns the old frame intact, and the swap plus CHANGED occur on the edge of the M_LAST handshake.
- Two frames complete during one stalled drain → one OVERRUN pulse, and the next drain returns the second frame.
- Assert RST during a drain at word 2 → M_VALID and SNAP_VALID go 0 immediately, and FRAME_CNT = 0.

Source files
------------

// File: rtl/usr_access_capture.sv
// Double-buffered capture of NUM_WORDS-word user-access frames with a valid/ready
// drain port, change detection, gap/overrun flags and a completed-frame counter.
module usr_access_capture #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WORDS  = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  dinvalid,
   input  logic                  start,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic                  snap_valid,
   output logic                  changed,
   output logic                  frame_err,
   output logic                  overrun,
   output logic [CNT_WIDTH-1:0]  frame_cnt
);

   localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] bank [2][NUM_WORDS];
   logic [IW-1:0]         wr_idx;
   logic [IW-1:0]         rd_idx;
   logic [IW-1:0]         rd_next;
   logic                  bank_sel;
   logic                  diff;
   logic                  diff_cur;
   logic                  pending;
   logic                  pend_dirty;
   logic                  pend_diff;
   logic                  last_word;
   logic                  gap;
   logic                  final_hs;
   logic                  draining;
   logic                  hs_swap;
   logic                  comp_swap;
   logic                  wr_bank;
   logic                  cmp_sel;
   logic [DATA_WIDTH-1:0] cmp_word;

   assign last_word = dinvalid && (wr_idx == LAST_IDX);
   assign gap       = !dinvalid && (wr_idx != '0);
   assign final_hs  = m_valid && m_ready && m_last;
   assign draining  = (state == DRAIN) && !final_hs;
   assign comp_swap = last_word && !draining;
   assign rd_next   = rd_idx + IW'(1);

   // A pending frame swaps in at the end of the drain only if no newer frame has
   // started overwriting its bank; otherwise it waits for that newer frame.
   assign hs_swap = final_hs && pending && !pend_dirty;

   // A word written on the swap edge belongs to the bank that becomes the fill bank.
   assign wr_bank  = ~bank_sel ^ hs_swap;
   assign cmp_sel  = bank_sel ^ hs_swap;
   assign cmp_word = bank[cmp_sel][wr_idx];
   assign diff_cur = ((wr_idx != '0) && diff) || (din != cmp_word) || !snap_valid;

   // NOTE: frame storage has no reset; snap_valid alone marks its contents valid,
   // which keeps the arrays out of the reset tree.
   always_ff @(posedge clk) begin
      if (dinvalid) begin
         bank[wr_bank][wr_idx] <= din;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every block
   // samples the pre-edge values regardless of evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_idx     <= '0;
         diff       <= 1'b0;
         bank_sel   <= 1'b0;
         snap_valid <= 1'b0;
         pending    <= 1'b0;
         pend_dirty <= 1'b0;
         pend_diff  <= 1'b0;
         changed    <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         changed   <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;

         if (dinvalid) begin
            wr_idx <= last_word ? '0 : wr_idx + IW'(1);
            diff   <= diff_cur;
         end else if (gap) begin
            wr_idx    <= '0;
            frame_err <= 1'b1;
         end

         if (last_word) begin
            frame_cnt  <= frame_cnt + CNT_WIDTH'(1);
            overrun    <= pending;
            pend_dirty <= 1'b0;
            if (draining) begin
               pending   <= 1'b1;
               pend_diff <= diff_cur;
            end else begin
               bank_sel   <= ~bank_sel;
               snap_valid <= 1'b1;
               changed    <= diff_cur;
               pending    <= 1'b0;
            end
         end else if (hs_swap) begin
            bank_sel <= ~bank_sel;
            changed  <= pend_diff;
            pending  <= 1'b0;
         end else if (gap && pending) begin
            // The aborted frame already clobbered the pending bank.
            pending    <= 1'b0;
            pend_dirty <= 1'b0;
         end else if (dinvalid && pending) begin
            pend_dirty <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         rd_idx  <= '0;
         m_valid <= 1'b0;
         m_last  <= 1'b0;
         m_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && snap_valid) begin
                  state   <= DRAIN;
                  rd_idx  <= '0;
                  m_valid <= 1'b1;
                  m_last  <= 1'b0;
                  m_data  <= bank[bank_sel ^ comp_swap][0];
               end
            end
            DRAIN: begin
               if (m_ready) begin
                  if (m_last) begin
                     state   <= IDLE;
                     m_valid <= 1'b0;
                     m_last  <= 1'b0;
                  end else begin
                     rd_idx <= rd_next;
                     m_data <= bank[bank_sel][rd_next];
                     m_last <= (rd_next == LAST_IDX);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_usr_access_capture.sv
// Directed bench for usr_access_capture: frame capture, change detect, gap,
// stalled drains with pending swap and overrun, and asynchronous reset.
module tb_usr_access_capture;

   localparam int DW = 32;
   localparam int NW = 4;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] din;
   logic          dinvalid;
   logic          start;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          m_last;
   logic          snap_valid;
   logic          changed;
   logic          frame_err;
   logic          overrun;
   logic [CW-1:0] frame_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   usr_access_capture #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .CNT_WIDTH(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .dinvalid  (dinvalid),
      .start     (start),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_last    (m_last),
      .snap_valid(snap_valid),
      .changed   (changed),
      .frame_err (frame_err),
      .overrun   (overrun),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NW*DW-1:0] mk(input logic [DW-1:0] w0, w1, w2, w3);
      return {w3, w2, w1, w0};
   endfunction

   task automatic send_frame(input logic [NW*DW-1:0] f);
      for (int i = 0; i < NW; i++) begin
         din      = f[i*DW +: DW];
         dinvalid = 1'b1;
         tick();
      end
      dinvalid = 1'b0;
      din      = '0;
   endtask

   task automatic drain_check(input string tag, input logic [NW*DW-1:0] f);
      start   = 1'b1;
      m_ready = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < NW; i++) begin
         check({tag, "_valid"}, m_valid, 1'b1);
         check({tag, "_data"}, m_data, f[i*DW +: DW]);
         check({tag, "_last"}, m_last, (i == NW - 1));
         tick();
      end
      check({tag, "_done"}, m_valid, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      logic [NW*DW-1:0] fa, fb, fc, fd;
      rst = 1'b1; din = '0; dinvalid = 1'b0; start = 1'b0; m_ready = 1'b0;
      tick();
      tick();
      check("rst_m_valid", m_valid, 1'b0);
      check("rst_m_data", m_data, '0);
      check("rst_snap", snap_valid, 1'b0);
      check("rst_cnt", frame_cnt, '0);
      check("rst_pulses", {changed, frame_err, overrun, m_last}, 4'b0000);
      rst = 1'b0;
      tick();

      // First frame after reset always reports a change.
      send_frame(mk(32'h11, 32'h22, 32'h33, 32'h44));
      check("f1_snap", snap_valid, 1'b1);
      check("f1_changed", changed, 1'b1);
      check("f1_cnt", frame_cnt, 16'd1);
      tick();
      check("f1_changed_pulse", changed, 1'b0);
      drain_check("d1", mk(32'h11, 32'h22, 32'h33, 32'h44));

      send_frame(mk(32'h11, 32'h22, 32'h33, 32'h44));
      check("f2_cnt", frame_cnt, 16'd2);
      check("f2_unchanged", changed, 1'b0);
      send_frame(mk(32'h11, 32'h22, 32'h99, 32'h44));
      check("f3_cnt", frame_cnt, 16'd3);
      check("f3_changed", changed, 1'b1);
      drain_check("d3", mk(32'h11, 32'h22, 32'h99, 32'h44));

      // Partial frame aborted by a one-cycle gap.
      din = 32'h55; dinvalid = 1'b1; tick();
      din = 32'h66; tick();
      dinvalid = 1'b0; din = '0; tick();
      check("gap_err", frame_err, 1'b1);
      check("gap_cnt", frame_cnt, 16'd3);
      tick();
      check("gap_err_pulse", frame_err, 1'b0);
      fa = mk(32'hA0, 32'hA1, 32'hA2, 32'hA3);
      send_frame(fa);
      check("fa_cnt", frame_cnt, 16'd4);
      check("fa_changed", changed, 1'b1);
      drain_check("da", fa);

      // Stalled drain while a new frame completes: swap deferred to last handshake.
      fb = mk(32'hB0, 32'hB1, 32'hB2, 32'hB3);
      start = 1'b1; m_ready = 1'b0; tick(); start = 1'b0;
      check("st_valid", m_valid, 1'b1);
      check("st_data0", m_data, 32'hA0);
      for (int i = 0; i < NW; i++) begin
         din = fb[i*DW +: DW]; dinvalid = 1'b1;
         tick();
         check("st_hold", m_data, 32'hA0);
         check("st_hold_last", m_last, 1'b0);
      end
      dinvalid = 1'b0; din = '0;
      check("st_cnt", frame_cnt, 16'd5);
      check("st_no_changed", changed, 1'b0);
      m_ready = 1'b1;
      tick(); check("st_data1", m_data, 32'hA1);
      tick(); check("st_data2", m_data, 32'hA2);
      tick(); check("st_data3", m_data, 32'hA3);
      check("st_last", m_last, 1'b1);
      check("st_changed_early", changed, 1'b0);
      tick();
      check("st_done", m_valid, 1'b0);
      check("st_swap_changed", changed, 1'b1);
      drain_check("db", fb);

      // Two frames during one stalled drain: one overrun, newer frame wins.
      fc = mk(32'hC0, 32'hC1, 32'hC2, 32'hC3);
      fd = mk(32'hD0, 32'hD1, 32'hD2, 32'hD3);
      start = 1'b1; m_ready = 1'b0; tick(); start = 1'b0;
      send_frame(fc);
      check("ov_c_none", overrun, 1'b0);
      check("ov_c_cnt", frame_cnt, 16'd6);
      send_frame(fd);
      check("ov_d_pulse", overrun, 1'b1);
      check("ov_d_cnt", frame_cnt, 16'd7);
      tick();
      check("ov_pulse_end", overrun, 1'b0);
      m_ready = 1'b1;
      for (int i = 0; i < NW; i++) begin
         check("ov_old_data", m_data, fb[i*DW +: DW]);
         tick();
      end
      check("ov_changed", changed, 1'b1);
      drain_check("dd", fd);

      // Asynchronous reset in the middle of a drain.
      start = 1'b1; m_ready = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      check("rd_word2", m_data, 32'hD2);
      #2 rst = 1'b1;
      #1;
      check("ar_valid", m_valid, 1'b0);
      check("ar_snap", snap_valid, 1'b0);
      check("ar_cnt", frame_cnt, '0);
      tick();
      rst = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      check("ar_start_ignored", m_valid, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
